div_share_arb: RTL

Round-robin arbiter and sequencer that shares one 8-bit radix-2 divider among N requesters. It accepts one operation at a time from the winning requester and issues it to the divider as a single-cycle start pulse. It then waits for the divider's done pulse, with a watchdog, and returns the 16-bit result to the owning requester under a valid/ready handshake. It sits between the requesting units and the shared divider instance.

---
 rtl/div_arb_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/div_share_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
package div_arb_pkg;
  localparam int DIV_W = 8;
  localparam int RES_W = 16;
  localparam logic [RES_W-1:0] TMO_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above i_ptr,
// wrapping from N-1 back to 0. Returns the one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] w_pos;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_pos = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_pos = PW'((int'(i_ptr) + k) % N);
      if (i_req[w_pos]) begin
        o_gnt        = '0;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end
endmodule

// File: rtl/div_share_arb.sv
// Shares one 8-bit divider among N requesters: round-robin grant, single-cycle
// start, watchdog-guarded wait, held response. Optional DIV_ARB_DIVZERO_EN
// answers zero-divisor requests directly without starting the divider.
module div_share_arb
  import div_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N-1:0]         req_sign,
  input  logic [DIV_W*N-1:0]   req_dividend,
  input  logic [DIV_W*N-1:0]   req_divisor,
  output logic [N-1:0]         resp_valid,
  input  logic [N-1:0]         resp_ready,
  output logic [RES_W-1:0]     resp_result,
  output logic                 resp_err,
  output logic                 div_opn_valid,
  output logic                 div_sign,
  output logic [DIV_W-1:0]     div_dividend,
  output logic [DIV_W-1:0]     div_divisor,
  input  logic                 div_res_valid,
  input  logic [RES_W-1:0]     div_result,
  output logic                 busy
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           r_state, w_next;
  logic [PW-1:0]    r_ptr, r_owner;
  logic             r_sign, r_err;
  logic [DIV_W-1:0] r_dvd, r_dvs;
  logic [RES_W-1:0] r_result;
  logic [CW-1:0]    r_wdog;

  logic [N-1:0]     w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_sel_sign, w_zero;
  logic [DIV_W-1:0] w_sel_dvd, w_sel_dvs;
  logic             w_accept, w_done, w_tmo, w_release;

  rr_arbiter #(.N(N)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_sel_sign = 1'b0;
    w_sel_dvd  = '0;
    w_sel_dvs  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_idx == PW'(i)) begin
        w_sel_sign = req_sign[i];
        w_sel_dvd  = req_dividend[i*DIV_W +: DIV_W];
        w_sel_dvs  = req_divisor[i*DIV_W +: DIV_W];
      end
    end
  end

`ifdef DIV_ARB_DIVZERO_EN
  assign w_zero = (w_sel_dvs == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: if (|req_valid) begin
        w_accept = 1'b1;
        w_next   = w_zero ? RESP : ISSUE;
      end
      ISSUE: w_next = WAIT;
      // A result arriving on the last watchdog cycle still wins.
      WAIT: if (div_res_valid) begin
        w_done = 1'b1;
        w_next = RESP;
      end else if (r_wdog == CW'(TIMEOUT - 1)) begin
        w_tmo  = 1'b1;
        w_next = RESP;
      end
      RESP: if (resp_ready[r_owner]) begin
        w_release = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_sign   <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_wdog   <= '0;
    end else begin
      r_wdog <= (r_state == WAIT) ? r_wdog + CW'(1) : '0;
      if (w_accept) begin
        r_owner <= w_idx;
        r_sign  <= w_sel_sign;
        r_dvd   <= w_sel_dvd;
        r_dvs   <= w_sel_dvs;
        if (w_zero) begin
          r_result <= {w_sel_dvd, {DIV_W{1'b1}}};
          r_err    <= 1'b1;
        end
      end
      if (w_done) begin
        r_result <= div_result;
        r_err    <= 1'b0;
      end
      if (w_tmo) begin
        r_result <= TMO_RESULT;
        r_err    <= 1'b1;
      end
      if (w_release)
        r_ptr <= (r_owner == PW'(N - 1)) ? '0 : r_owner + PW'(1);
    end
  end

  // Grant is combinational; keep it quiet while reset is held.
  assign req_ready = (r_state == IDLE && !rst) ? w_gnt : '0;

  always_comb begin
    resp_valid = '0;
    if (r_state == RESP) resp_valid[r_owner] = 1'b1;
  end

  assign resp_result   = r_result;
  assign resp_err      = r_err;
  assign div_opn_valid = (r_state == ISSUE);
  assign div_sign      = r_sign;
  assign div_dividend  = r_dvd;
  assign div_divisor   = r_dvs;
  assign busy          = (r_state != IDLE);
endmodule
